// File: rtl/ks_sub_pipe_64_pkg.sv
// ============================================================================
// Module : ks_sub_pipe_64_pkg
// Brief  : Shared widths and stage-register layout for the pipelined subtractor
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ks_sub_pipe_64_pkg;

  localparam int SLICE_W = 8;
  localparam int N_SLICE = 8;
  localparam int W       = SLICE_W * N_SLICE;

  // Operand vectors travel whole; each stage only consumes its own slice of
  // a_hi/b_hi and fills its own slice of diff_lo.
  typedef struct packed {
    logic         valid;
    logic         carry;
    logic [W-1:0] diff_lo;
    logic [W-1:0] a_hi;
    logic [W-1:0] b_hi;
    logic         a_msb;
    logic         b_msb;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/ks_sub_pipe_64_sub_slice_8.sv
// ============================================================================
// Module : sub_slice_8
// Brief  : Combinational one-slice subtract, {c, d} = a + ~b + c_in
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_slice_8
  import ks_sub_pipe_64_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_c,
  output logic [SLICE_W-1:0] o_d,
  output logic               o_c
);

  logic [SLICE_W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{SLICE_W{1'b0}}, i_c};
  assign o_d   = w_sum[SLICE_W-1:0];
  assign o_c   = w_sum[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/ks_sub_pipe_64.sv
// ============================================================================
// Module : ks_sub_pipe_64
// Brief  : 64-bit a - b - bin, one 8-bit slice per stage, valid/ready pipeline
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ks_sub_pipe_64
  import ks_sub_pipe_64_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_diff,
  output logic         o_bout,
  output logic         o_ovf
);

  stage_t             r_stage [N_SLICE];
  logic [N_SLICE:0]   w_load;

  // Fall-through ready chain: an empty stage always loads, so bubbles collapse.
  assign w_load[N_SLICE] = i_out_ready;

  for (genvar k = 0; k < N_SLICE; k++) begin : g_stage
    logic         w_src_valid;
    logic         w_src_cin;
    logic [W-1:0] w_src_diff;
    logic [W-1:0] w_src_a;
    logic [W-1:0] w_src_b;
    logic         w_src_amsb;
    logic         w_src_bmsb;
    logic [SLICE_W-1:0] w_d;
    logic         w_c;
    logic [W-1:0] w_next_diff;

    assign w_load[k] = ~r_stage[k].valid | w_load[k+1];

    if (k == 0) begin : g_first
      assign w_src_valid = i_in_valid & w_load[0];
      assign w_src_cin   = ~i_bin;
      assign w_src_diff  = '0;
      assign w_src_a     = i_a;
      assign w_src_b     = i_b;
      assign w_src_amsb  = i_a[W-1];
      assign w_src_bmsb  = i_b[W-1];
    end else begin : g_rest
      assign w_src_valid = r_stage[k-1].valid;
      assign w_src_cin   = r_stage[k-1].carry;
      assign w_src_diff  = r_stage[k-1].diff_lo;
      assign w_src_a     = r_stage[k-1].a_hi;
      assign w_src_b     = r_stage[k-1].b_hi;
      assign w_src_amsb  = r_stage[k-1].a_msb;
      assign w_src_bmsb  = r_stage[k-1].b_msb;
    end

    sub_slice_8 u_slice (
      .i_a (w_src_a[k*SLICE_W +: SLICE_W]),
      .i_b (w_src_b[k*SLICE_W +: SLICE_W]),
      .i_c (w_src_cin),
      .o_d (w_d),
      .o_c (w_c)
    );

    always_comb begin
      w_next_diff                        = w_src_diff;
      w_next_diff[k*SLICE_W +: SLICE_W]  = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stage[k] <= '0;
      end else if (w_load[k]) begin
        r_stage[k].valid   <= w_src_valid;
        r_stage[k].carry   <= w_c;
        r_stage[k].diff_lo <= w_next_diff;
        r_stage[k].a_hi    <= w_src_a;
        r_stage[k].b_hi    <= w_src_b;
        r_stage[k].a_msb   <= w_src_amsb;
        r_stage[k].b_msb   <= w_src_bmsb;
      end
    end
  end

  assign o_in_ready  = w_load[0];
  assign o_out_valid = r_stage[N_SLICE-1].valid;
  assign o_diff      = r_stage[N_SLICE-1].diff_lo;
  // Gated by valid so the cleared carry does not read as a borrow after reset.
  assign o_bout      = r_stage[N_SLICE-1].valid & ~r_stage[N_SLICE-1].carry;
  assign o_ovf       = (r_stage[N_SLICE-1].a_msb ^ r_stage[N_SLICE-1].b_msb)
                     & (r_stage[N_SLICE-1].diff_lo[W-1] ^ r_stage[N_SLICE-1].a_msb);

endmodule

`default_nettype wire

// File: tb/tb_ks_sub_pipe_64.sv
// ============================================================================
// Module : tb_ks_sub_pipe_64
// Brief  : Self-checking bench for ks_sub_pipe_64 against an arithmetic model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ks_sub_pipe_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [63:0] i_a;
  logic [63:0] i_b;
  logic        i_bin;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [63:0] o_diff;
  logic        o_bout;
  logic        o_ovf;

  always #5 clk = ~clk;

  ks_sub_pipe_64 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_bin       (i_bin),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_diff      (o_diff),
    .o_bout      (o_bout),
    .o_ovf       (o_ovf)
  );

  typedef struct {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  res_t obs;
  int   total = 0;
  int   bad   = 0;
  int   tick_n = 0;
  int   dlv_cnt = 0;
  int   first_dlv_tick = 0;
  int   last_dlv_tick = 0;
  logic last_acc;
  logic last_dlv;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
    res_t        r;
    logic [64:0] t;
    t      = {1'b0, a} - {1'b0, b} - 65'(bin);
    r.diff = t[63:0];
    r.bout = t[64];
    r.ovf  = (a[63] != b[63]) && (r.diff[63] != a[63]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  // One clock: drive at the falling edge, sample mid-cycle, then wait a cycle.
  task automatic tick(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic bin, input logic ordy);
    res_t e;
    i_in_valid  = v;
    i_a         = a;
    i_b         = b;
    i_bin       = bin;
    i_out_ready = ordy;
    #1;
    last_acc = v && o_in_ready;
    last_dlv = o_out_valid && ordy;
    if (last_dlv) begin
      dlv_cnt++;
      if (dlv_cnt == 1) first_dlv_tick = tick_n;
      last_dlv_tick = tick_n;
      obs.diff = o_diff;
      obs.bout = o_bout;
      obs.ovf  = o_ovf;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_out observed=0x%0h expected=none", o_diff);
      end else begin
        e = exp_q.pop_front();
        chk("diff", o_diff, e.diff);
        chk("bout", 64'(o_bout), 64'(e.bout));
        chk("ovf", 64'(o_ovf), 64'(e.ovf));
      end
    end
    if (last_acc) exp_q.push_back(model(a, b, bin));
    @(negedge clk);
    tick_n++;
  endtask

  task automatic single(input logic [63:0] a, input logic [63:0] b, input logic bin,
                        output int lat);
    int t0;
    dlv_cnt = 0;
    lat = -1;
    tick(1'b1, a, b, bin, 1'b1);
    chk("accept", 64'(last_acc), 64'd1);
    t0 = tick_n - 1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      if (last_dlv) begin
        lat = last_dlv_tick - t0;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] va [12];
  logic [63:0] vb [12];
  logic        vbin [12];
  logic [63:0] held;
  int          lat;
  int          idx;

  initial begin
    rst_n = 1'b0;
    i_in_valid = 1'b0; i_a = '0; i_b = '0; i_bin = 1'b0; i_out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(o_out_valid), 64'd0);
    chk("rst_diff", o_diff, 64'd0);
    chk("rst_bout", 64'(o_bout), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 64'(o_in_ready), 64'd1);
    @(negedge clk);

    // Directed arithmetic cases
    single(64'd5, 64'd3, 1'b0, lat);
    chk("d1_diff", obs.diff, 64'd2);
    chk("d1_bout", 64'(obs.bout), 64'd0);
    chk("d1_ovf", 64'(obs.ovf), 64'd0);
    single(64'd0, 64'd1, 1'b0, lat);
    chk("d2_diff", obs.diff, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("d2_bout", 64'(obs.bout), 64'd1);
    chk("d2_ovf", 64'(obs.ovf), 64'd0);
    single(64'h8000_0000_0000_0000, 64'd1, 1'b0, lat);
    chk("d3_diff", obs.diff, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("d3_bout", 64'(obs.bout), 64'd0);
    chk("d3_ovf", 64'(obs.ovf), 64'd1);
    single(64'h1234, 64'h1234, 1'b1, lat);
    chk("d4_diff", obs.diff, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("d4_bout", 64'(obs.bout), 64'd1);

    // 16 back-to-back random vectors
    dlv_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      chk("b2b_accept", 64'(last_acc), 64'd1);
    end
    for (int i = 0; i < 30 && exp_q.size() > 0; i++)
      tick(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    chk("b2b_count", 64'(dlv_cnt), 64'd16);
    chk("b2b_consecutive", 64'(last_dlv_tick - first_dlv_tick), 64'd15);

    // Backpressure: 12 vectors with the consumer stalled
    for (int i = 0; i < 12; i++) begin
      va[i]   = {$urandom, $urandom};
      vb[i]   = {$urandom, $urandom};
      vbin[i] = 1'($urandom_range(0, 1));
    end
    va[3] = 64'd0; vb[3] = 64'hFFFF_FFFF_FFFF_FFFF; vbin[3] = 1'b1;
    idx = 0;
    dlv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, va[idx], vb[idx], vbin[idx], 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_accepts", 64'(idx), 64'd8);
    i_in_valid = 1'b1; i_out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", 64'(o_in_ready), 64'd0);
    i_out_ready = 1'b1;
    #1;
    chk("bp_fallthrough", 64'(o_in_ready), 64'd1);
    i_out_ready = 1'b0;
    @(negedge clk);
    held = o_diff;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      chk("bp_hold_valid", 64'(o_out_valid), 64'd1);
      chk("bp_hold_diff", o_diff, held);
    end
    for (int i = 0; i < 80 && (idx < 12 || exp_q.size() > 0); i++) begin
      tick(idx < 12, va[idx < 12 ? idx : 0], vb[idx < 12 ? idx : 0],
           vbin[idx < 12 ? idx : 0], 1'(i % 2));
      if (last_acc) idx++;
    end
    chk("bp_all_sent", 64'(idx), 64'd12);
    chk("bp_all_drained", 64'(dlv_cnt), 64'd12);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with work in flight
    for (int i = 0; i < 4; i++)
      tick(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    for (int i = 0; i < 12 && !o_out_valid; i++)
      tick(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("ar_pre_valid", 64'(o_out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(o_out_valid), 64'd0);
    chk("ar_diff", o_diff, 64'd0);
    chk("ar_bout", 64'(o_bout), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single(64'd10, 64'd4, 1'b0, lat);
    chk("ar_new_diff", obs.diff, 64'd6);
    chk("ar_single_out", 64'(dlv_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
